fir_transpose_param: RTL and testbench
======================================

# fir_transpose_param

Parametrised transposed-form FIR filter for the DSP datapath. It is the next generation of the fixed 32-tap, 12-bit filter. It adds generic tap count and widths, a valid-qualified sample stream, and a runtime-loadable double-buffered coefficient bank with a settle phase after each coefficient swap. It sits between the ADC front end and the DAC or decimation stages.

## Interface
- NUM_TAPS, 32, number of taps, ≥ 2
- DIN_W, 12, signed input sample width
- COEFF_W, 16, signed coefficient width
- DOUT_W, 12, signed output width
- OUT_SHIFT, 15, arithmetic right shift applied to the accumulator to form dout, 0 ≤ OUT_SHIFT ≤ ACC_W−DOUT_W
- ACC_W, localparam = DIN_W+COEFF_W+$clog2(NUM_TAPS), accumulator width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  din is a new sample this cycle
- din  in  DIN_W  signed sample
- out_valid  out  1  dout holds a new, fully settled output
- dout  out  DOUT_W  signed filter output
- coef_wr_en  in  1  write coef_data into the shadow bank
- coef_addr  in  $clog2(NUM_TAPS)  shadow bank index j (tap applied to x[n−j])
- coef_data  in  COEFF_W  signed coefficient
- coef_commit  in  1  copy the shadow bank into the active bank
- coef_busy  out  1  settle phase in progress
- sat  out  1  saturation occurred on the current output (FIR_ROUND_SAT_EN only)

## Operation
- Output definition: y[n] = Σ c_active[j]·x[n−j] for j = 0..NUM_TAPS−1, computed as a full-precision signed ACC_W sum with no intermediate overflow.
- Transposed chain: acc[0] ← x·c[NUM_TAPS−1], and acc[k] ← acc[k−1] + x·c[NUM_TAPS−1−k]. Products use the active bank.
- Chain gating: the chain advances only on cycles with in_valid = 1. Idle cycles hold all state, dout, and sample history.
- Shadow bank writes: coef_wr_en = 1 writes shadow[coef_addr] ← coef_data. Writes with coef_addr ≥ NUM_TAPS are ignored. Writes never affect the active bank directly.
- Commit: coef_commit = 1 sets active ← shadow at that edge. If a write occurs in the same cycle, the written value is included (forwarded).
- States: RUN and SETTLE, with a settle counter cnt.
  - Reset state is RUN with cnt = 0.
  - A commit in any state moves to SETTLE and loads cnt = NUM_TAPS−1. A commit during SETTLE restarts the counter.
  - In SETTLE, each accepted sample (in_valid = 1, no commit in that cycle) decrements cnt. The sample that brings cnt from 1 to 0 returns the block to RUN.
- out_valid: registered, = in_valid & (state == RUN) & ~coef_commit, evaluated in the acceptance cycle.
  - A sample accepted in the commit cycle uses the pre-commit coefficients, and its output is suppressed.
  - The NUM_TAPS−1 samples accepted during SETTLE are also suppressed.
- coef_busy = (state == SETTLE).
- Output formatting (macro absent): dout = acc_last[OUT_SHIFT+DOUT_W−1 : OUT_SHIFT], truncating and wrapping. sat is tied to 0.

## Timing
- Latency: a sample accepted at edge t produces dout and out_valid from edge t onward, i.e. one cycle after in_valid. dout is combinational from the last accumulator register.
- dout holds its value between valid outputs. out_valid is a single-cycle pulse per accepted sample.
- Throughput: one sample per clock.
- Reset values: all accumulators 0; shadow and active banks 0; dout = 0; out_valid = 0; coef_busy = 0; sat = 0; state RUN.
- Reset mid-SETTLE aborts the settle phase and clears both banks.

## Configuration
- FIR_ROUND_SAT_EN defined:
  - dout = saturate_DOUT_W((acc_last + 2^(OUT_SHIFT−1)) >>> OUT_SHIFT), rounding half up. The rounding term is 0 when OUT_SHIFT = 0.
  - Values clip to [−2^(DOUT_W−1), 2^(DOUT_W−1)−1].
  - sat = 1 exactly when clipping occurs on the current dout.
- FIR_ROUND_SAT_EN undefined: truncation and wrap as described under Operation; sat is constant 0.

## Test plan
- Impulse response (NUM_TAPS=4, OUT_SHIFT=0, DOUT_W=16): load c = 1,2,3,4, commit, then feed 3 zeros and 1, 0, 0, 0 back-to-back → dout = 1,2,3,4 with out_valid on all four.
- Settle (NUM_TAPS=4): commit concurrent with in_valid, then 3 more samples → out_valid low for all 4 and coef_busy high for 3 cycles; the 5th sample → out_valid = 1.
- Gaps: impulse with in_valid duty 1/3 → same dout sequence 1,2,3,4; dout held and out_valid low in gap cycles.
- Saturation (macro on, DIN_W=12, OUT_SHIFT=0, DOUT_W=16): c[0..3] = 32767, din = 2047 repeated → dout = 32767 with sat = 1. Same test with the macro off → wrapped low 16 bits, sat = 0.
- Address guard: write coef_addr = 5 with NUM_TAPS = 4 (addr width 2 wraps, so test with NUM_TAPS=5 and addr 7) → active bank unchanged after commit; impulse response unaffected.
- Reset mid-SETTLE: assert rst_n low after 1 settle sample → all outputs 0, coef_busy = 0; the next sample yields out_valid = 1, dout = 0.

Source files
------------

// File: rtl/fir_transpose_param.sv
// Transposed-form FIR with valid-gated chain and double-buffered coefficients.
// Optional FIR_ROUND_SAT_EN: round-half-up and saturate dout, drive sat.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid, din         sample stream input
//   out_valid, dout, sat  filtered output (out_valid pulses per settled sample)
//   coef_wr_en, coef_addr, coef_data   shadow bank write port
//   coef_commit           copy shadow bank (with same-cycle write) into active
//   coef_busy             settle phase after a commit
module fir_transpose_param #(
    parameter int NUM_TAPS  = 32,
    parameter int DIN_W     = 12,
    parameter int COEFF_W   = 16,
    parameter int DOUT_W    = 12,
    parameter int OUT_SHIFT = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic signed [DIN_W-1:0]     din,
    output logic                        out_valid,
    output logic signed [DOUT_W-1:0]    dout,
    input  logic                        coef_wr_en,
    input  logic [$clog2(NUM_TAPS)-1:0] coef_addr,
    input  logic signed [COEFF_W-1:0]   coef_data,
    input  logic                        coef_commit,
    output logic                        coef_busy,
    output logic                        sat
);

    localparam int AW    = $clog2(NUM_TAPS);
    localparam int PW    = DIN_W + COEFF_W;
    localparam int ACC_W = DIN_W + COEFF_W + $clog2(NUM_TAPS);

    typedef enum logic {
        RUN,
        SETTLE
    } state_t;

    state_t state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;

    logic signed [COEFF_W-1:0] shadow [NUM_TAPS];
    logic signed [COEFF_W-1:0] active [NUM_TAPS];
    logic signed [PW-1:0]      prod   [NUM_TAPS];
    logic signed [ACC_W-1:0]   acc    [NUM_TAPS];
    logic [NUM_TAPS-1:0]       wr_hit;
    logic                      settle_step;

    // Out-of-range addresses hit no tap, so they are dropped silently.
    always_comb begin
        for (int j = 0; j < NUM_TAPS; j++) begin
            wr_hit[j] = coef_wr_en && (int'(coef_addr) == j);
        end
    end

    // A write landing in the commit cycle is forwarded into the active bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NUM_TAPS; j++) begin
                shadow[j] <= '0;
                active[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_TAPS; j++) begin
                if (wr_hit[j]) begin
                    shadow[j] <= coef_data;
                end
                if (coef_commit) begin
                    active[j] <= wr_hit[j] ? coef_data : shadow[j];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            prod[k] = din * active[NUM_TAPS-1-k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                acc[k] <= '0;
            end
        end else if (in_valid) begin
            acc[0] <= ACC_W'(prod[0]);
            for (int k = 1; k < NUM_TAPS; k++) begin
                acc[k] <= acc[k-1] + ACC_W'(prod[k]);
            end
        end
    end

    assign settle_step = (state == SETTLE) && in_valid && !coef_commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The chain holds mixed old/new partial sums until NUM_TAPS-1 samples
    // have entered after the swap.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (1'b1)
            coef_commit: begin
                state_nxt = SETTLE;
                cnt_nxt   = AW'(NUM_TAPS - 1);
            end
            settle_step: begin
                if (cnt == AW'(1)) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - AW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid && (state == RUN) && !coef_commit;
        end
    end

    assign coef_busy = (state == SETTLE);

`ifdef FIR_ROUND_SAT_EN
    localparam int RW = ACC_W + 1;
    localparam int RS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
    localparam logic signed [RW-1:0] ONE =
        {{(RW-1){1'b0}}, 1'b1};
    localparam logic signed [RW-1:0] RND =
        (OUT_SHIFT == 0) ? '0 : (ONE << RS);
    localparam logic signed [RW-1:0] SMAX =
        {{(RW-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
    localparam logic signed [RW-1:0] SMIN =
        {{(RW-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};

    logic signed [RW-1:0] rnd_sum;
    logic signed [RW-1:0] shifted;

    // One guard bit keeps the rounding add from overflowing.
    always_comb begin
        rnd_sum = RW'(acc[NUM_TAPS-1]) + RND;
        shifted = rnd_sum >>> OUT_SHIFT;
        sat     = 1'b0;
        dout    = shifted[DOUT_W-1:0];
        if (shifted > SMAX) begin
            dout = SMAX[DOUT_W-1:0];
            sat  = 1'b1;
        end else if (shifted < SMIN) begin
            dout = SMIN[DOUT_W-1:0];
            sat  = 1'b1;
        end
    end
`else
    assign dout = acc[NUM_TAPS-1][OUT_SHIFT+DOUT_W-1:OUT_SHIFT];
    assign sat  = 1'b0;
`endif

endmodule

// File: tb/tb_fir_transpose_param.sv
// Self-checking bench for fir_transpose_param (5 taps, 16-bit out, shift 0).
// Reference is a direct-form history sum checked through a scoreboard queue.
module tb_fir_transpose_param;

    localparam int NT = 5;
    localparam int DW = 12;
    localparam int CW = 16;
    localparam int OW = 16;
    localparam int SH = 0;
    localparam int AW = 3;
    localparam longint RND =
        (SH > 0) ? (longint'(1) <<< ((SH > 0) ? SH - 1 : 0)) : 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic coef_wr_en = 1'b0;
    logic coef_commit = 1'b0;
    logic signed [DW-1:0] din = '0;
    logic [AW-1:0] coef_addr = '0;
    logic signed [CW-1:0] coef_data = '0;
    logic out_valid, coef_busy, sat;
    logic signed [OW-1:0] dout;

    always #5 clk = ~clk;

    fir_transpose_param #(
        .NUM_TAPS(NT), .DIN_W(DW), .COEFF_W(CW),
        .DOUT_W(OW), .OUT_SHIFT(SH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din(din),
        .out_valid(out_valid), .dout(dout),
        .coef_wr_en(coef_wr_en), .coef_addr(coef_addr),
        .coef_data(coef_data), .coef_commit(coef_commit),
        .coef_busy(coef_busy), .sat(sat)
    );

    typedef struct {
        logic ov;
        logic busy;
        logic known;
        logic [OW-1:0] d;
        logic s;
    } exp_t;

    typedef struct {
        bit iv; int x; bit we; int a; int d; bit cm;
        bit ov; bit chk; int dv;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int checks = 0;
    int errors = 0;

    int sh_m[NT];
    int ac_m[NT];
    int hist[NT];
    bit settle_m;
    int cnt_m;
    logic [OW-1:0] dout_m;
    logic sat_m;
    bit known_m;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, req, $time);
        end
    endtask

    function automatic void fmt(input longint y, output logic [OW-1:0] d,
                                output logic s);
        longint r;
`ifdef FIR_ROUND_SAT_EN
        longint mx;
        longint mn;
        mx = (longint'(1) <<< (OW - 1)) - 1;
        mn = -(longint'(1) <<< (OW - 1));
        r = (y + RND) >>> SH;
        s = 1'b0;
        if (r > mx) begin
            r = mx;
            s = 1'b1;
        end else if (r < mn) begin
            r = mn;
            s = 1'b1;
        end
`else
        r = (y + 0 * RND) >>> SH;
        s = 1'b0;
`endif
        d = r[OW-1:0];
    endfunction

    task automatic model_reset();
        for (int j = 0; j < NT; j++) begin
            sh_m[j] = 0;
            ac_m[j] = 0;
            hist[j] = 0;
        end
        settle_m = 0;
        cnt_m = 0;
        dout_m = '0;
        sat_m = 1'b0;
        known_m = 1;
        sb.delete();
    endtask

    task automatic drive(input bit iv, input int x, input bit we,
                         input int a, input int d, input bit cm);
        exp_t e;
        exp_t g;
        longint y;
        e.ov = iv && !settle_m && !cm;
        if (iv) begin
            for (int j = NT - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = x;
            y = 0;
            for (int j = 0; j < NT; j++)
                y += longint'(ac_m[j]) * longint'(hist[j]);
            fmt(y, dout_m, sat_m);
            known_m = e.ov;
        end
        if (cm) begin
            settle_m = 1;
            cnt_m = NT - 1;
        end else if (settle_m && iv) begin
            cnt_m--;
            if (cnt_m == 0) settle_m = 0;
        end
        if (we && a < NT) sh_m[a] = d;
        if (cm) for (int j = 0; j < NT; j++) ac_m[j] = sh_m[j];
        e.busy = settle_m;
        e.known = known_m;
        e.d = dout_m;
        e.s = sat_m;
        sb.push_back(e);
        in_valid = iv;
        din = DW'(x);
        coef_wr_en = we;
        coef_addr = AW'(a);
        coef_data = CW'(d);
        coef_commit = cm;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty actual=0 required=1");
        end else begin
            g = sb.pop_front();
            chk("sb_out_valid", 64'(out_valid), 64'(g.ov));
            chk("sb_coef_busy", 64'(coef_busy), 64'(g.busy));
            if (g.known) begin
                chk("sb_dout", 64'($unsigned(dout)), 64'(g.d));
                chk("sb_sat", 64'(sat), 64'(g.s));
            end
        end
    endtask

    task automatic do_reset();
        in_valid = 0;
        coef_wr_en = 0;
        coef_commit = 0;
        rst_n = 0;
        #2;
        model_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_dout", 64'($unsigned(dout)), 64'd0);
        chk("rst_coef_busy", 64'(coef_busy), 64'd0);
        chk("rst_sat", 64'(sat), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    function automatic void add(bit iv, int x, bit we, int a, int d,
                                bit cm, bit ov, bit ck, int dv);
        vec_t v;
        v.iv = iv; v.x = x; v.we = we; v.a = a; v.d = d; v.cm = cm;
        v.ov = ov; v.chk = ck; v.dv = dv;
        tbl.push_back(v);
    endfunction

    function automatic void add_impulse(int gap);
        add(1, 1, 0, 0, 0, 0, 1, 1, 1);
        for (int k = 2; k <= 5; k++) begin
            for (int g = 0; g < gap; g++)
                add(0, 0, 0, 0, 0, 0, 0, 1, k - 1);
            add(1, 0, 0, 0, 0, 0, 1, 1, (k == 5) ? 0 : k);
        end
    endfunction

    function automatic void add_settle_zeros();
        for (int k = 0; k < NT - 1; k++)
            add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    int busy_n;
    int ov_n;
    logic [OW-1:0] sat_d;
    logic sat_s;

    initial begin
        model_reset();
        add(0, 0, 1, 0, 1, 0, 0, 1, 0);
        add(0, 0, 1, 1, 2, 0, 0, 1, 0);
        add(0, 0, 1, 2, 3, 0, 0, 1, 0);
        add(0, 0, 1, 3, 4, 1, 0, 1, 0);
        add_settle_zeros();
        add_impulse(0);
        add_impulse(2);
        add(0, 0, 1, 7, 99, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0, 1, 0);
        add_settle_zeros();
        add_impulse(0);

        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].iv, tbl[i].x, tbl[i].we, tbl[i].a,
                  tbl[i].d, tbl[i].cm);
            chk($sformatf("tbl%0d_out_valid", i),
                64'(out_valid), 64'(tbl[i].ov));
            if (tbl[i].chk)
                chk($sformatf("tbl%0d_dout", i),
                    64'($unsigned(dout)), 64'(OW'(tbl[i].dv)));
        end

        busy_n = 0;
        ov_n = 0;
        drive(1, 7, 0, 0, 0, 1);
        busy_n += int'(coef_busy);
        ov_n += int'(out_valid);
        for (int k = 0; k < NT - 1; k++) begin
            drive(1, 3 * k - 4, 0, 0, 0, 0);
            busy_n += int'(coef_busy);
            ov_n += int'(out_valid);
        end
        chk("settle_busy_cycles", 64'(busy_n), 64'(NT - 1));
        chk("settle_ov_count", 64'(ov_n), 64'd0);
        drive(1, 9, 0, 0, 0, 0);
        chk("settle_first_valid", 64'(out_valid), 64'd1);

        for (int j = 0; j < 4; j++) drive(0, 0, 1, j, 32767, 0);
        drive(0, 0, 1, 4, 0, 1);
        for (int k = 0; k < NT + 2; k++) drive(1, 2047, 0, 0, 0, 0);
`ifdef FIR_ROUND_SAT_EN
        sat_d = 16'h7fff;
        sat_s = 1'b1;
`else
        sat_d = 16'he004;
        sat_s = 1'b0;
`endif
        chk("satur_out_valid", 64'(out_valid), 64'd1);
        chk("satur_dout", 64'($unsigned(dout)), 64'(sat_d));
        chk("satur_sat", 64'(sat), 64'(sat_s));

        for (int j = 0; j < NT; j++)
            drive(0, 0, 1, j, int'($urandom_range(0, 65535)) - 32768, 0);
        drive(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 80; k++) begin
            drive($urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 4095)) - 2048,
                  $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 65535)) - 32768,
                  $urandom_range(0, 24) == 0);
        end

        drive(0, 0, 0, 0, 0, 1);
        drive(1, 11, 0, 0, 0, 0);
        chk("pre_rst_busy", 64'(coef_busy), 64'd1);
        do_reset();
        drive(1, 5, 0, 0, 0, 0);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_dout", 64'($unsigned(dout)), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
